// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: programs a PWM (period, counter, compare) and then walks the
// compare value toward a target in bounded steps, one step every N PWM periods.
module pwm_ramp_ctrl #(
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [15:0]       top_cfg,
   input  logic [15:0]       target,
   input  logic [15:0]       step,
   input  logic [HOLD_W-1:0] hold,
   input  logic [15:0]       pwm_cnt,
   output logic [1:0]        sel,
   output logic [15:0]       d,
   output logic [15:0]       duty,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_TOP = 3'd1,
      WR_CNT = 3'd2,
      WR_CMP = 3'd3,
      WAIT   = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Ramp parameters captured at start; the live inputs are ignored afterwards.
   typedef struct packed {
      logic [15:0]       top;
      logic [15:0]       target;
      logic [15:0]       step;
      logic [HOLD_W-1:0] hold;
   } cfg_t;

   localparam logic [1:0]        SEL_NONE = 2'd0;
   localparam logic [1:0]        SEL_CMP  = 2'd1;
   localparam logic [1:0]        SEL_TOP  = 2'd2;
   localparam logic [1:0]        SEL_CNT  = 2'd3;
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   state_t            state_q, state_d;
   cfg_t              cfg_q;
   logic [HOLD_W-1:0] per_cnt_q;
   logic [15:0]       duty_q;

   logic [15:0] up_gap, dn_gap, nxt;
   logic        period_hit, last_period;

   assign duty = duty_q;

   // Next compare value: move by step but clamp at the gap so target is never
   // overshot; gaps are only used on the side where they cannot underflow.
   always_comb begin
      up_gap = cfg_q.target - duty_q;
      dn_gap = duty_q - cfg_q.target;
      nxt    = cfg_q.target;
      if (cfg_q.step == 16'd0 || duty_q == cfg_q.target)
         nxt = cfg_q.target;
      else if (duty_q < cfg_q.target)
         nxt = duty_q + ((cfg_q.step < up_gap) ? cfg_q.step : up_gap);
      else
         nxt = duty_q - ((cfg_q.step < dn_gap) ? cfg_q.step : dn_gap);
   end

   // A PWM period boundary is seen as the counter reaching the latched top.
   always_comb begin
      period_hit  = (pwm_cnt >= cfg_q.top);
      last_period = period_hit && (per_cnt_q <= HOLD_ONE);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and write-port decode; write data is forced to 0 when idle.
   always_comb begin
      state_d = state_q;
      sel     = SEL_NONE;
      d       = 16'd0;
      busy    = 1'b1;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = WR_TOP;
         end
         WR_TOP: begin
            sel     = SEL_TOP;
            d       = cfg_q.top;
            state_d = WR_CNT;
         end
         WR_CNT: begin
            sel     = SEL_CNT;
            state_d = WR_CMP;
         end
         WR_CMP: begin
            sel     = SEL_CMP;
            d       = nxt;
            state_d = (nxt == cfg_q.target) ? DONE : WAIT;
         end
         WAIT: begin
            if (last_period) state_d = WR_CMP;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: capture config, track duty, count PWM periods between steps.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q     <= '0;
         per_cnt_q <= '0;
         duty_q    <= 16'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  cfg_q.top    <= top_cfg;
                  cfg_q.target <= target;
                  cfg_q.step   <= step;
                  cfg_q.hold   <= (hold == '0) ? HOLD_ONE : hold;
               end
            end
            WR_CMP: begin
               duty_q <= nxt;
               if (nxt != cfg_q.target) per_cnt_q <= cfg_q.hold;
            end
            WAIT: begin
               if (period_hit) per_cnt_q <= per_cnt_q - HOLD_ONE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: one linear sequence of ramps with
// hand-computed write sequences, checked one cycle at a time.
module tb_pwm_ramp_ctrl;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] top_cfg, target, step, pwm_cnt;
   logic [7:0]  hold;
   logic [1:0]  sel;
   logic [15:0] d, duty;
   logic        busy, done;

   int checks = 0;
   int errors = 0;

   pwm_ramp_ctrl #(.HOLD_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .top_cfg(top_cfg), .target(target),
      .step(step), .hold(hold), .pwm_cnt(pwm_cnt), .sel(sel), .d(d),
      .duty(duty), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Advance one edge, then sample/drive 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic [1:0] es, input logic [15:0] ed);
      chk({tag, ".sel"}, 32'(sel), 32'(es));
      chk({tag, ".d"},   32'(d),   32'(ed));
   endtask

   task automatic cfg(input logic [15:0] tp, input logic [15:0] tg,
                      input logic [15:0] st, input logic [7:0] hd);
      top_cfg = tp; target = tg; step = st; hold = hd;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pwm_cnt = 16'd0;
      cfg(16'd0, 16'd0, 16'd0, 8'd0);

      // Reset state
      tick();
      rst = 1'b0;
      chk_wr("rst", 2'd0, 16'd0);
      chk("rst.duty", 32'(duty), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);

      // Ramp up 0 -> 6, step 2, hold 1, top 9
      cfg(16'd9, 16'd6, 16'd2, 8'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg(16'd50, 16'd60, 16'd7, 8'd3);  // must be ignored once latched
      chk_wr("up.top", 2'd2, 16'd9);
      chk("up.busy", 32'(busy), 32'd1);
      tick(); chk_wr("up.cnt", 2'd3, 16'd0);
      tick(); chk_wr("up.cmp2", 2'd1, 16'd2);
      tick(); chk_wr("up.wait", 2'd0, 16'd0);
      chk("up.duty2", 32'(duty), 32'd2);
      pwm_cnt = 16'd5;
      tick(); chk_wr("up.wait_lo", 2'd0, 16'd0);
      pwm_cnt = 16'd9;
      tick(); chk_wr("up.cmp4", 2'd1, 16'd4);
      tick(); chk_wr("up.wait2", 2'd0, 16'd0);
      tick(); chk_wr("up.cmp6", 2'd1, 16'd6);
      pwm_cnt = 16'd0;
      tick();
      chk("up.done", 32'(done), 32'd1);
      chk("up.done_sel", 32'(sel), 32'd0);
      chk("up.duty6", 32'(duty), 32'd6);
      tick();
      chk("up.idle_done", 32'(done), 32'd0);
      chk("up.idle_busy", 32'(busy), 32'd0);

      // Ramp down 6 -> 1, step 4, hold 2: cmp 2 then saturated 1
      cfg(16'd9, 16'd1, 16'd4, 8'd2);
      start = 1'b1;
      tick(); start = 1'b0;
      chk_wr("dn.top", 2'd2, 16'd9);
      tick(); chk_wr("dn.cnt", 2'd3, 16'd0);
      tick(); chk_wr("dn.cmp2", 2'd1, 16'd2);
      tick(); chk_wr("dn.wait", 2'd0, 16'd0);
      pwm_cnt = 16'd9;
      tick(); chk_wr("dn.wait_1st", 2'd0, 16'd0);
      tick(); chk_wr("dn.cmp1", 2'd1, 16'd1);
      pwm_cnt = 16'd0;
      tick(); chk("dn.done", 32'(done), 32'd1);
      chk("dn.duty1", 32'(duty), 32'd1);
      tick(); chk("dn.done_once", 32'(done), 32'd0);
      tick(); chk("dn.still_idle", 32'(done), 32'd0);

      // step 0 jumps straight to target
      cfg(16'd9, 16'd100, 16'd0, 8'd1);
      start = 1'b1;
      tick(); start = 1'b0;
      chk_wr("jmp.top", 2'd2, 16'd9);
      tick(); chk_wr("jmp.cnt", 2'd3, 16'd0);
      tick(); chk_wr("jmp.cmp", 2'd1, 16'd100);
      tick(); chk("jmp.done", 32'(done), 32'd1);
      chk("jmp.duty", 32'(duty), 32'd100);
      tick(); chk("jmp.idle", 32'(busy), 32'd0);

      // hold 0 acts as 1; start held during busy does not restart
      cfg(16'd9, 16'd104, 16'd2, 8'd0);
      start = 1'b1;
      tick(); chk_wr("h0.top", 2'd2, 16'd9);
      tick(); chk_wr("h0.cnt", 2'd3, 16'd0);
      tick(); chk_wr("h0.cmp102", 2'd1, 16'd102);
      tick(); chk_wr("h0.wait", 2'd0, 16'd0);
      pwm_cnt = 16'd9;
      tick(); chk_wr("h0.cmp104", 2'd1, 16'd104);
      pwm_cnt = 16'd0;
      tick(); chk("h0.done", 32'(done), 32'd1);
      chk("h0.done_sel", 32'(sel), 32'd0);
      start = 1'b0;
      tick(); chk("h0.idle", 32'(busy), 32'd0);
      chk("h0.idle_sel", 32'(sel), 32'd0);
      tick(); chk("h0.no_restart", 32'(busy), 32'd0);

      // target equal to current duty: still three writes then done
      cfg(16'd9, 16'd104, 16'd3, 8'd1);
      start = 1'b1;
      tick(); start = 1'b0;
      chk_wr("eq.top", 2'd2, 16'd9);
      tick(); chk_wr("eq.cnt", 2'd3, 16'd0);
      tick(); chk_wr("eq.cmp", 2'd1, 16'd104);
      tick(); chk("eq.done", 32'(done), 32'd1);
      tick(); chk("eq.idle", 32'(busy), 32'd0);

      // Reset during WAIT
      cfg(16'd9, 16'd110, 16'd1, 8'd5);
      start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      chk_wr("rw.cmp105", 2'd1, 16'd105);
      tick(); chk("rw.wait_busy", 32'(busy), 32'd1);
      pwm_cnt = 16'd9;
      rst = 1'b1;
      tick();
      chk_wr("rw.rst", 2'd0, 16'd0);
      chk("rw.duty", 32'(duty), 32'd0);
      chk("rw.busy", 32'(busy), 32'd0);
      chk("rw.done", 32'(done), 32'd0);

      // start together with rst is ignored
      start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      chk("rs.busy", 32'(busy), 32'd0);
      tick();
      chk("rs.busy2", 32'(busy), 32'd0);
      chk_wr("rs.idle", 2'd0, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter HOLD_W, default 8: width of the periods-per-step field.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a ramp; sampled only in IDLE.
- top_cfg  in  16  PWM period value to program.
- target  in  16  final duty (compare) value.
- step  in  16  duty change per step; 0 = jump directly to target.
- hold  in  HOLD_W  PWM periods between steps; 0 treated as 1.
- pwm_cnt  in  16  counter feedback from the driven PWM.
- sel  out  2  PWM write select: 0 none, 1 cmp, 2 top, 3 cnt.
- d  out  16  PWM write data.
- duty  out  16  last compare value written.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on ramp completion.

Function
REQ-003 States SHALL be IDLE, WR_TOP, WR_CNT, WR_CMP, WAIT, DONE; the FSM SHALL occupy exactly one state per cycle.
REQ-004 IDLE: sel=0, d=0; when start=1, the block SHALL latch top_cfg, target, step and hold (0 mapped to 1) and go to WR_TOP.
REQ-005 WR_TOP: sel=2, d=latched top for exactly one cycle, then WR_CNT.
REQ-006 WR_CNT: sel=3, d=0 for exactly one cycle, then WR_CMP.
REQ-007 WR_CMP: the block SHALL compute next = duty+min(step, target-duty) if duty<target, duty-min(step, duty-target) if duty>target, target if duty==target or step==0; it SHALL drive sel=1, d=next, and register duty<=next.
REQ-008 Arithmetic SHALL be unsigned 16-bit with no wrap: next never overshoots target in either direction.
REQ-009 From WR_CMP, the FSM SHALL go to DONE if next==target, else to WAIT with period counter loaded with latched hold.
REQ-010 WAIT: sel=0, d=0; each cycle with pwm_cnt >= latched top SHALL decrement the period counter; the cycle that decrements it from 1 to 0 SHALL transition to WR_CMP.
REQ-011 DONE: done=1, sel=0 for one cycle, then IDLE.
REQ-012 Latency: start sampled at edge k gives sel=2 in cycle k+1, sel=3 in k+2, first sel=1 in k+3.
REQ-013 start SHALL be ignored in every state other than IDLE; inputs other than pwm_cnt SHALL be ignored after latching.
REQ-014 A ramp with target equal to current duty SHALL still perform WR_TOP, WR_CNT, one WR_CMP writing duty, then DONE.
REQ-015 sel SHALL be nonzero only in WR_TOP, WR_CNT, WR_CMP; d SHALL be 0 whenever sel=0.

Reset
REQ-016 rst=1 at a clock edge SHALL force IDLE, duty=0, sel=0, d=0, busy=0, done=0, and clear all latched fields and the period counter, regardless of state.
REQ-017 Reset mid-ramp SHALL NOT issue any further PWM write; the PWM keeps its last programmed values.
REQ-018 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-019 Reset, start with top_cfg=9, target=6, step=2, hold=1 -> sel/d sequence 2/9, 3/0, 1/2, then after pwm_cnt reaches 9: 1/4, then 1/6, then done pulse; duty ends at 6.
REQ-020 From duty=6, target=1, step=4, hold=2 -> writes cmp 2 then 1 (saturated), two pwm_cnt>=top events between writes, done once.
REQ-021 step=0, target=100 -> single cmp write of 100 at cycle k+3, done at k+4.
REQ-022 hold=0 -> behaves identically to hold=1; start pulses during busy -> no restart, no extra writes.
REQ-023 rst asserted during WAIT -> next cycle IDLE, duty=0, busy=0, sel=0, no done pulse.
REQ-024 target equal to current duty -> writes top, cnt 0, cmp=duty, done pulse after three write cycles.
